// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_adder
// Description : Pipelined add/subtract unit with N/Z/C/V flags. The carry
//               chain is split into STAGES registered chunks of WIDTH/STAGES
//               bits each. Valid/ready handshake on both sides. The optional
//               signed saturation is selected by defining ADDER_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_adder #(
    parameter int WIDTH  = 16,  // operand/result width, multiple of STAGES
    parameter int STAGES = 2    // pipeline depth = number of carry chunks
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);

    localparam int CW = WIDTH / STAGES;

`ifdef ADDER_SATURATE_EN
    localparam bit c_SATURATE = 1'b1;
`else
    localparam bit c_SATURATE = 1'b0;
`endif

    // Whole pipe moves together: it advances unless a result is waiting.
    logic w_adv;

    // Inputs of each stage: stage 0 from the ports, stage k from register k-1.
    logic             w_vld_in [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_s_in   [STAGES];
    logic             w_c_in   [STAGES];

    // Final-stage registers, driven from the last generate iteration.
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             r_v;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign N         = r_n;
    assign Z         = r_z;
    assign C         = r_c;
    assign V         = r_v;

    // Subtraction is a + ~b + 1: invert b here and use sub as carry-in.
    assign w_vld_in[0] = in_valid;
    assign w_a_in[0]   = in1;
    assign w_b_in[0]   = sub ? ~in2 : in2;
    assign w_s_in[0]   = '0;
    assign w_c_in[0]   = sub;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [CW-1:0]    w_chunk;
            logic             w_cout;
            logic [WIDTH-1:0] w_sum;

            // Chunk k of the carry chain.
            assign {w_cout, w_chunk} = {1'b0, w_a_in[k][k*CW +: CW]}
                                     + {1'b0, w_b_in[k][k*CW +: CW]}
                                     + {{CW{1'b0}}, w_c_in[k]};

            // Merge the new chunk into the partial sum carried so far.
            always_comb begin
                w_sum               = w_s_in[k];
                w_sum[k*CW +: CW]   = w_chunk;
            end

            if (k < STAGES - 1) begin : g_mid
                logic             r_vld;
                logic [WIDTH-1:0] r_a;
                logic [WIDTH-1:0] r_b;
                logic [WIDTH-1:0] r_s;
                logic             r_cy;

                // Intermediate stage register: partial sum, carry, operands.
                always_ff @(posedge clock) begin
                    if (rst_any(reset)) begin
                        r_vld <= 1'b0;
                        r_a   <= '0;
                        r_b   <= '0;
                        r_s   <= '0;
                        r_cy  <= 1'b0;
                    end else if (w_adv) begin
                        r_vld <= w_vld_in[k];
                        if (w_vld_in[k]) begin
                            r_a  <= w_a_in[k];
                            r_b  <= w_b_in[k];
                            r_s  <= w_sum;
                            r_cy <= w_cout;
                        end
                    end
                end

                assign w_vld_in[k+1] = r_vld;
                assign w_a_in[k+1]   = r_a;
                assign w_b_in[k+1]   = r_b;
                assign w_s_in[k+1]   = r_s;
                assign w_c_in[k+1]   = r_cy;
            end else begin : g_last
                logic             w_ovf;
                logic             w_a_msb;
                logic [WIDTH-1:0] w_res;

                // Overflow detection and optional clamp to the signed limit.
                always_comb begin
                    w_a_msb = w_a_in[k][WIDTH-1];
                    w_ovf   = (w_a_msb == w_b_in[k][WIDTH-1]) &&
                              (w_sum[WIDTH-1] != w_a_msb);
                    w_res   = w_sum;
                    if (c_SATURATE && w_ovf) begin
                        w_res = w_a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
                    end
                end

                // Result register; flags derive from the value driven on out.
                always_ff @(posedge clock) begin
                    if (rst_any(reset)) begin
                        r_out_valid <= 1'b0;
                        r_out       <= '0;
                        r_n         <= 1'b0;
                        r_z         <= 1'b0;
                        r_c         <= 1'b0;
                        r_v         <= 1'b0;
                    end else if (w_adv) begin
                        r_out_valid <= w_vld_in[k];
                        if (w_vld_in[k]) begin
                            r_out <= w_res;
                            r_n   <= w_res[WIDTH-1];
                            r_z   <= (w_res == '0);
                            r_c   <= w_cout;
                            r_v   <= w_ovf;
                        end
                    end
                end
            end
        end
    endgenerate

    // Reset qualifier kept as a function so every register shares one rule.
    function automatic logic rst_any(input logic i_rst);
        return i_rst;
    endfunction

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_adder
// Description : Self-checking bench for pipe_adder. Two instances:
//               WIDTH=16/STAGES=2 and WIDTH=32/STAGES=4. Expected results
//               come from a full-width reference model held in scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

`ifdef ADDER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [15:0] in1, in2, out;
    logic        n, z, c, v;

    logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4;
    logic [31:0] in1_4, in2_4, out4;
    logic        n4, z4, c4, v4;

    exp_t        q16[$];
    exp_t        q32[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    pipe_adder #(.WIDTH(16), .STAGES(2)) u_dut16 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .N(n), .Z(z), .C(c), .V(v)
    );

    pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in1(in1_4), .in2(in2_4), .sub(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out(out4),
        .N(n4), .Z(z4), .C(c4), .V(v4)
    );

    // Full-width reference: one wide addition, then flags and clamp.
    function automatic exp_t model(input int w, input logic [31:0] a,
                                   input logic [31:0] b, input logic s);
        longint unsigned mask, aa, bb, full, r;
        exp_t e;
        logic am;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = s ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        full = aa + bb + {63'd0, s};
        r    = full & mask;
        am   = aa[w-1];
        e.c  = full[w];
        e.v  = (am == bb[w-1]) && (r[w-1] != am);
        if (SAT && e.v)
            r = am ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
        e.res = r[31:0];
        e.n   = r[w-1];
        e.z   = (r == 64'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_val(input int w);
        logic [31:0] x;
        case ($urandom_range(0, 5))
            0:       x = 32'd0;
            1:       x = 32'hFFFF_FFFF;
            2:       x = (32'd1 << (w-1)) - 32'd1;
            3:       x = 32'd1 << (w-1);
            default: x = $urandom;
        endcase
        if (w < 32) x = x & ((32'd1 << w) - 32'd1);
        return x;
    endfunction

    task automatic idle();
        in_valid = 1'b0; in1 = '0; in2 = '0; sub = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; in1_4 = '0; in2_4 = '0; sub4 = 1'b0; out_ready4 = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        in_valid = 1'b1; in1 = 16'h1234; in2 = 16'h0001;
        in_valid4 = 1'b1; in1_4 = 32'h1; in2_4 = 32'h1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0 || {n, z, c, v} !== 4'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b out=%h nzcv=%b, expected 0 1 0000 0000",
                     out_valid, in_ready, out, {n, z, c, v});
        end
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state_wide: got valid=%b ready=%b out=%h, expected 0 1 0",
                     out_valid4, in_ready4, out4);
        end
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_wins: got out_valid=%b expected 0", out_valid);
            end
        end
    endtask

    task automatic test_flags();
        logic [15:0] ta [6];
        logic [15:0] tb [6];
        logic        ts [6];
        logic [15:0] eo [6];
        logic [3:0]  ef [6];
        ta = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h0003, 16'h8000, 16'h8000};
        tb = '{16'h0001, 16'h0001, 16'h0005, 16'h0005, 16'h0001, 16'h8000};
        ts = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
        // flags are {N,Z,C,V}
`ifdef ADDER_SATURATE_EN
        eo = '{16'h7FFF, 16'h0000, 16'h0000, 16'hFFFE, 16'h8000, 16'h8000};
        ef = '{4'b0001,  4'b0110,  4'b0110,  4'b1000,  4'b1011,  4'b1011};
`else
        eo = '{16'h8000, 16'h0000, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h0000};
        ef = '{4'b1001,  4'b0110,  4'b0110,  4'b1000,  4'b0011,  4'b0111};
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            in1 = ta[i]; in2 = tb[i]; sub = ts[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clock);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flags_latency_%0d: got out_valid=%b after 1 cycle, expected 0", i, out_valid);
            end
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out !== eo[i] || {n, z, c, v} !== ef[i]) begin
                errors++;
                $display("FAIL flags_%0d: got valid=%b out=%h nzcv=%b, expected 1 %h %b",
                         i, out_valid, out, {n, z, c, v}, eo[i], ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa [4];
        logic [15:0] ob [4];
        logic        os [4];
        exp_t        e;
        int          i = 0, seen = 0, first_acc = -1, last_cyc = 0;
        oa = '{16'h00FF, 16'h0FFF, 16'h1234, 16'h8000};
        ob = '{16'h0001, 16'h0001, 16'h0235, 16'h0001};
        os = '{1'b0,     1'b0,     1'b1,     1'b1};
        for (int t = 0; t < 20 && (i < 4 || q16.size() > 0); t++) begin
            @(negedge clock);
            out_ready = 1'b1;
            if (i < 4) begin
                in_valid = 1'b1; in1 = oa[i]; in2 = ob[i]; sub = os[i];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got out=%h with empty scoreboard", out);
                end else begin
                    e = q16.pop_front();
                    if ({out, n, z, c, v} !== {e.res[15:0], e.n, e.z, e.c, e.v}) begin
                        errors++;
                        $display("FAIL b2b_result_%0d: got %h/%b expected %h/%b",
                                 seen, out, {n, z, c, v}, e.res[15:0], {e.n, e.z, e.c, e.v});
                    end
                end
                checks++;
                if ((seen == 0 && cyc != first_acc + 2) || (seen > 0 && cyc != last_cyc + 1)) begin
                    errors++;
                    $display("FAIL b2b_timing_%0d: got cycle %0d, first accept %0d last result %0d",
                             seen, cyc, first_acc, last_cyc);
                end
                last_cyc = cyc;
                seen++;
            end
            if (in_valid && in_ready) begin
                q16.push_back(model(16, {16'd0, in1}, {16'd0, in2}, sub));
                if (first_acc < 0) first_acc = cyc;
                i++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (seen != 4 || q16.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, %0d left, expected 4 and 0", seen, q16.size());
        end
    endtask

    task automatic test_stall();
        logic [15:0] oa [3];
        logic [15:0] ob [3];
        logic        os [3];
        logic [19:0] snap;
        exp_t        e;
        int          i = 0, seen = 0;
        oa = '{16'h00FF, 16'h7FFF, 16'h1000};
        ob = '{16'h0001, 16'h7FFF, 16'h2000};
        os = '{1'b0,     1'b0,     1'b1};
        snap = '0;
        for (int t = 0; t < 30 && (i < 3 || q16.size() > 0); t++) begin
            @(negedge clock);
            out_ready = (t >= 5);
            if (i < 3) begin
                in_valid = 1'b1; in1 = oa[i]; in2 = ob[i]; sub = os[i];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t >= 2 && t <= 4) begin
                if (t == 2) snap = {out, n, z, c, v};
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out, n, z, c, v} !== snap) begin
                    errors++;
                    $display("FAIL stall_hold_%0d: got ready=%b valid=%b out/flags=%h, expected 0 1 %h",
                             t, in_ready, out_valid, {out, n, z, c, v}, snap);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL stall_unexpected: got out=%h with empty scoreboard", out);
                end else begin
                    e = q16.pop_front();
                    if ({out, n, z, c, v} !== {e.res[15:0], e.n, e.z, e.c, e.v}) begin
                        errors++;
                        $display("FAIL stall_result_%0d: got %h/%b expected %h/%b",
                                 seen, out, {n, z, c, v}, e.res[15:0], {e.n, e.z, e.c, e.v});
                    end
                end
                seen++;
            end
            if (in_valid && in_ready) begin
                q16.push_back(model(16, {16'd0, in1}, {16'd0, in2}, sub));
                i++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (seen != 3 || q16.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got %0d results, %0d left, valid=%b, expected 3 0 0",
                     seen, q16.size(), out_valid);
        end
    endtask

    task automatic test_reset_inflight();
        exp_t e;
        idle();
        @(negedge clock); in_valid = 1'b1; in1 = 16'h1111; in2 = 16'h2222;
        @(negedge clock); in1 = 16'h3333; in2 = 16'h4444;
        @(negedge clock); reset = 1'b1; in1 = 16'h5555; in2 = 16'h0001;
        @(negedge clock); reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_inflight: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: got out_valid=%b out=%h expected 0", out_valid, out);
        end
        in_valid = 1'b1; in1 = 16'h00FF; in2 = 16'h0F01; sub = 1'b1;
        e = model(16, 32'h00FF, 32'h0F01, 1'b1);
        @(negedge clock); in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || {out, n, z, c, v} !== {e.res[15:0], e.n, e.z, e.c, e.v}) begin
            errors++;
            $display("FAIL reset_newop: got valid=%b %h/%b expected 1 %h/%b",
                     out_valid, out, {n, z, c, v}, e.res[15:0], {e.n, e.z, e.c, e.v});
        end
    endtask

    task automatic test_wide();
        idle();
        @(negedge clock);
        in_valid4 = 1'b1; in1_4 = 32'h0FFF_FFFF; in2_4 = 32'h0000_0001;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            in_valid4 = 1'b0;
            checks++;
            if ((k < 4 && out_valid4 !== 1'b0) ||
                (k == 4 && (out_valid4 !== 1'b1 || out4 !== 32'h1000_0000 || {n4, z4, c4, v4} !== 4'b0))) begin
                errors++;
                $display("FAIL wide_carry_%0d: got valid=%b out=%h nzcv=%b, expected valid=%b out=10000000 nzcv=0000",
                         k, out_valid4, out4, {n4, z4, c4, v4}, (k == 4));
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            in_valid   = ($urandom_range(0, 3) != 0) && (t < 2980);
            in1        = rand_val(16);
            in2        = rand_val(16);
            sub        = $urandom_range(0, 1);
            out_ready  = ($urandom_range(0, 9) < 7) || (t >= 2980);
            in_valid4  = ($urandom_range(0, 3) != 0) && (t < 2980);
            in1_4      = rand_val(32);
            in2_4      = rand_val(32);
            sub4       = $urandom_range(0, 1);
            out_ready4 = ($urandom_range(0, 9) < 7) || (t >= 2980);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL rand16_unexpected: got out=%h with empty scoreboard", out);
                end else begin
                    e = q16.pop_front();
                    if ({out, n, z, c, v} !== {e.res[15:0], e.n, e.z, e.c, e.v}) begin
                        errors++;
                        $display("FAIL rand16_result: got %h/%b expected %h/%b",
                                 out, {n, z, c, v}, e.res[15:0], {e.n, e.z, e.c, e.v});
                    end
                end
            end
            if (in_valid && in_ready)
                q16.push_back(model(16, {16'd0, in1}, {16'd0, in2}, sub));
            if (out_valid4 && out_ready4) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL rand32_unexpected: got out=%h with empty scoreboard", out4);
                end else begin
                    e = q32.pop_front();
                    if ({out4, n4, z4, c4, v4} !== {e.res, e.n, e.z, e.c, e.v}) begin
                        errors++;
                        $display("FAIL rand32_result: got %h/%b expected %h/%b",
                                 out4, {n4, z4, c4, v4}, e.res, {e.n, e.z, e.c, e.v});
                    end
                end
            end
            if (in_valid4 && in_ready4)
                q32.push_back(model(32, in1_4, in2_4, sub4));
        end
        idle();
        @(negedge clock);
        checks++;
        if (q16.size() != 0 || q32.size() != 0 || out_valid !== 1'b0 || out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got %0d/%0d results outstanding, expected 0/0",
                     q16.size(), q32.size());
        end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_wide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete within time bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
